// File: rtl/pulse_gate_counter.sv
// Gated rising-edge counter: opens a GATE_CYCLES window on OE, publishes the count with counter_data_en.
// Optional glitch filter between synchronizer and edge detector: define PULSE_CNT_GLITCH_FILTER_EN.
module pulse_gate_counter #(
   parameter int unsigned GATE_CYCLES   = 50_000_000,
   parameter int unsigned CNT_W         = 32,
   parameter int unsigned FILTER_CYCLES = 4
) (
   input  logic             sys_clk,
   input  logic             sys_rst,
   input  logic             OE,
   input  logic             sig_in,
   output logic             counter_data_en,
   output logic [CNT_W-1:0] pulse_count,
   output logic             cnt_ovf
);

   localparam int unsigned GATE_W = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
   localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);

   if (GATE_CYCLES < 2 || FILTER_CYCLES < 1) begin : g_bad_params
      $error("pulse_gate_counter: GATE_CYCLES must be >= 2 and FILTER_CYCLES >= 1");
   end

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_GATE,
      ST_DONE
   } state_t;

   logic              sync1_q;
   logic              sync2_q;
   logic              level;
   logic              level_prev_q;
   logic              edge_p_q;

   state_t            state_q;
   logic [GATE_W-1:0] gate_cnt_q;
   logic [CNT_W-1:0]  acc_q;
   logic [CNT_W-1:0]  acc_d;
   logic              acc_ovf_q;
   logic              acc_ovf_d;
   logic              data_en_q;
   logic [CNT_W-1:0]  pulse_count_q;
   logic              cnt_ovf_q;

   // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= sig_in;
         sync2_q <= sync1_q;
      end
   end

`ifdef PULSE_CNT_GLITCH_FILTER_EN
   localparam int unsigned FILT_W = (FILTER_CYCLES > 2) ? $clog2(FILTER_CYCLES) : 1;

   logic              filt_q;
   logic [FILT_W-1:0] filt_cnt_q;

   // Counts consecutive cycles the synchronized input disagrees with the filtered level.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         filt_q     <= 1'b0;
         filt_cnt_q <= '0;
      end else if (sync2_q == filt_q) begin
         filt_cnt_q <= '0;
      end else if (filt_cnt_q == FILT_W'(FILTER_CYCLES - 1)) begin
         filt_q     <= sync2_q;
         filt_cnt_q <= '0;
      end else begin
         filt_cnt_q <= filt_cnt_q + 1'b1;
      end
   end

   assign level = filt_q;
`else
   assign level = sync2_q;
`endif

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         level_prev_q <= 1'b0;
         edge_p_q     <= 1'b0;
      end else begin
         level_prev_q <= level;
         edge_p_q     <= level & ~level_prev_q;
      end
   end

   // NOTE: every always_comb output gets a default first so no latch can be inferred.
   always_comb begin
      acc_d     = acc_q;
      acc_ovf_d = acc_ovf_q;
      if (edge_p_q) begin
         if (&acc_q) begin
            acc_ovf_d = 1'b1;
         end else begin
            acc_d = acc_q + 1'b1;
         end
      end
   end

   // Abort has priority over the gate-end load, so an interrupted gate never publishes.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q       <= ST_IDLE;
         gate_cnt_q    <= '0;
         acc_q         <= '0;
         acc_ovf_q     <= 1'b0;
         data_en_q     <= 1'b0;
         pulse_count_q <= '0;
         cnt_ovf_q     <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (OE) begin
                  gate_cnt_q <= '0;
                  acc_q      <= '0;
                  acc_ovf_q  <= 1'b0;
                  state_q    <= ST_GATE;
               end
            end
            ST_GATE: begin
               if (!OE) begin
                  state_q <= ST_IDLE;
               end else begin
                  gate_cnt_q <= gate_cnt_q + 1'b1;
                  acc_q      <= acc_d;
                  acc_ovf_q  <= acc_ovf_d;
                  if (gate_cnt_q == GATE_LAST) begin
                     pulse_count_q <= acc_d;
                     cnt_ovf_q     <= acc_ovf_d;
                     data_en_q     <= 1'b1;
                     state_q       <= ST_DONE;
                  end
               end
            end
            ST_DONE: begin
               if (!OE) begin
                  data_en_q <= 1'b0;
                  state_q   <= ST_IDLE;
               end
            end
            default: begin
               data_en_q <= 1'b0;
               state_q   <= ST_IDLE;
            end
         endcase
      end
   end

   assign counter_data_en = data_en_q;
   assign pulse_count     = pulse_count_q;
   assign cnt_ovf         = cnt_ovf_q;

endmodule

// File: tb/tb_pulse_gate_counter.sv
// Self-checking bench for pulse_gate_counter: a cycle-indexed history of sig_in feeds a
// window-count model of each gate; outputs are compared on every falling edge.
module tb_pulse_gate_counter;

   localparam int G    = 100;
   localparam int W    = 4;
   localparam int F    = 4;
   localparam int MAXV = (1 << W) - 1;
   localparam int MAXC = 8192;
`ifdef PULSE_CNT_GLITCH_FILTER_EN
   localparam bit FILT = 1'b1;
`else
   localparam bit FILT = 1'b0;
`endif

   logic         sys_clk = 1'b0;
   logic         sys_rst;
   logic         OE;
   logic         sig_in;
   logic         counter_data_en;
   logic [W-1:0] pulse_count;
   logic         cnt_ovf;

   pulse_gate_counter #(
      .GATE_CYCLES  (G),
      .CNT_W        (W),
      .FILTER_CYCLES(F)
   ) dut (
      .sys_clk        (sys_clk),
      .sys_rst        (sys_rst),
      .OE             (OE),
      .sig_in         (sig_in),
      .counter_data_en(counter_data_en),
      .pulse_count    (pulse_count),
      .cnt_ovf        (cnt_ovf)
   );

   always #5 sys_clk = ~sys_clk;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- reference model ----------------
   bit hist [MAXC];   // sig_in as sampled at the end of each cycle (0 while in reset)
   bit fh   [MAXC];   // that history after the stability filter

   typedef enum {M_IDLE, M_GATE, M_DONE} mphase_t;
   mphase_t      ph         = M_IDLE;
   int           c0         = 0;
   bit           model_live = 1'b0;
   logic         exp_den    = 1'b0;
   logic [W-1:0] exp_cnt    = '0;
   logic         exp_ovf    = 1'b0;

   function automatic bit hv(input int k);
      return (k >= 0 && k < MAXC) ? hist[k] : 1'b0;
   endfunction

   function automatic bit fv(input int k);
      return (k >= 0 && k < MAXC) ? fh[k] : 1'b0;
   endfunction

   // Edge pulse seen during cycle t: 3 cycles after the rise, F more with the filter.
   function automatic bit ep(input int t);
      if (FILT) return fv(t - 4) & ~fv(t - 5);
      return hv(t - 3) & ~hv(t - 4);
   endfunction

   initial begin
      forever begin
         int t;
         int edges;
         bit same;
         @(posedge sys_clk);
         t = cyc;
         if (t < MAXC) begin
            hist[t] = sys_rst ? 1'b0 : sig_in;
            if (sys_rst) begin
               fh[t] = 1'b0;
            end else begin
               same = 1'b1;
               for (int i = 1; i < F; i++) if (hv(t - i) != hist[t]) same = 1'b0;
               fh[t] = same ? hist[t] : fv(t - 1);
            end
         end
         if (sys_rst) begin
            ph = M_IDLE; exp_den = 1'b0; exp_cnt = '0; exp_ovf = 1'b0; model_live = 1'b1;
         end else if (model_live) begin
            case (ph)
               M_IDLE: if (OE) begin c0 = t; ph = M_GATE; end
               M_GATE: begin
                  if (!OE) begin
                     ph = M_IDLE;
                  end else if (t == c0 + G) begin
                     edges = 0;
                     for (int u = c0 + 1; u <= c0 + G; u++) edges += int'(ep(u));
                     exp_cnt = (edges > MAXV) ? W'(MAXV) : W'(edges);
                     exp_ovf = (edges > MAXV);
                     exp_den = 1'b1;
                     ph      = M_DONE;
                  end
               end
               default: if (!OE) begin exp_den = 1'b0; ph = M_IDLE; end
            endcase
         end
         cyc = t + 1;
      end
   end

   initial begin
      forever begin
         @(negedge sys_clk);
         if (model_live) begin
            check("model_den",   32'(counter_data_en), 32'(exp_den));
            check("model_count", 32'(pulse_count),     32'(exp_cnt));
            check("model_ovf",   32'(cnt_ovf),         32'(exp_ovf));
         end
      end
   end

   // ---------------- sig_in generator ----------------
   int pat_mode = 1;   // 0: periodic from pat_base (per 0 = static low), 1: random toggling
   int pat_per  = 0;
   int pat_hi   = 0;
   int pat_base = 0;
   int pat_tdiv = 2;

   initial begin
      sig_in = 1'b0;
      forever begin
         @(negedge sys_clk);
         if (pat_mode == 1) begin
            if ($urandom_range(pat_tdiv - 1, 0) == 0) sig_in = ~sig_in;
         end else if (pat_per == 0 || cyc < pat_base) begin
            sig_in = 1'b0;
         end else begin
            sig_in = ((cyc - pat_base) % pat_per) < pat_hi;
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic start_gate(input int per, input int hi, input int off, output int c0_o);
      int plan;
      pat_mode = 0;
      plan     = cyc + 6;
      pat_per  = per;
      pat_hi   = hi;
      pat_base = plan + off;
      repeat (6) @(negedge sys_clk);
      c0_o = cyc;
      OE   = 1'b1;
   endtask

   task automatic wait_den(input int budget, output int seen);
      seen = -1;
      for (int i = 0; i < budget; i++) begin
         @(negedge sys_clk);
         if (counter_data_en === 1'b1) begin
            seen = cyc;
            break;
         end
      end
      if (seen < 0) check("den_timeout", 32'(counter_data_en), 32'd1);
   endtask

   task automatic drop_oe();
      OE = 1'b0;
      @(negedge sys_clk);
      check("den_fall", 32'(counter_data_en), 32'd0);
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      int c0v;
      int seen;
      int act;
      int n;
      sys_rst = 1'b1;
      OE      = 1'b1;

      repeat (3) begin
         @(negedge sys_clk);
         check("rst_den",   32'(counter_data_en), 32'd0);
         check("rst_count", 32'(pulse_count),     32'd0);
         check("rst_ovf",   32'(cnt_ovf),         32'd0);
      end
      sys_rst = 1'b0;
      c0v     = cyc;
      wait_den(G + 20, seen);
      check("first_gate_latency", 32'(seen), 32'(c0v + G + 1));
      drop_oe();

      start_gate(10, 5, 2, c0v);
      wait_den(G + 20, seen);
      check("basic_latency", 32'(seen), 32'(c0v + G + 1));
      check("basic_count", 32'(pulse_count), 32'd10);
      check("basic_ovf",   32'(cnt_ovf),     32'd0);
      repeat (20) begin
         @(negedge sys_clk);
         check("hold_den",   32'(counter_data_en), 32'd1);
         check("hold_count", 32'(pulse_count),     32'd10);
      end
      drop_oe();

      start_gate(20, 10, 2, c0v);
      wait_den(G + 20, seen);
      check("second_count", 32'(pulse_count), 32'd5);
      drop_oe();

      start_gate(10, 5, 2, c0v);
      wait_den(G + 20, seen);
      check("pre_abort_count", 32'(pulse_count), 32'd10);
      drop_oe();
      start_gate(20, 10, 2, c0v);
      repeat (50) @(negedge sys_clk);
      OE = 1'b0;
      repeat (150) @(negedge sys_clk);
      check("abort_den",   32'(counter_data_en), 32'd0);
      check("abort_count", 32'(pulse_count),     32'd10);

      start_gate(4, 2, 1, c0v);
      wait_den(G + 20, seen);
      check("ovf_count", 32'(pulse_count), FILT ? 32'd0 : 32'd15);
      check("ovf_flag",  32'(cnt_ovf),     FILT ? 32'd0 : 32'd1);
      drop_oe();
      start_gate(0, 0, 0, c0v);
      wait_den(G + 20, seen);
      check("static_count", 32'(pulse_count), 32'd0);
      check("static_ovf",   32'(cnt_ovf),     32'd0);
      drop_oe();

      start_gate(10, 2, 2, c0v);
      wait_den(G + 20, seen);
      check("glitch_count", 32'(pulse_count), FILT ? 32'd0 : 32'd10);
      drop_oe();

      for (int it = 0; it < 14; it++) begin
         act      = $urandom_range(3, 0);
         pat_tdiv = $urandom_range(8, 1);
         pat_mode = 1;
         repeat (2) @(negedge sys_clk);
         OE = 1'b1;
         case (act)
            0, 1: begin
               wait_den(G + 20, seen);
               n = $urandom_range(5, 0);
               repeat (n) @(negedge sys_clk);
               OE = 1'b0;
               @(negedge sys_clk);
               if (act == 1) begin
                  OE = 1'b1;
                  wait_den(G + 20, seen);
                  OE = 1'b0;
                  @(negedge sys_clk);
               end
            end
            2: begin
               n = $urandom_range(G - 1, 1);
               repeat (n) @(negedge sys_clk);
               OE = 1'b0;
               @(negedge sys_clk);
            end
            default: begin
               n = $urandom_range(90, 5);
               repeat (n) @(negedge sys_clk);
               sys_rst = 1'b1;
               repeat (4) @(negedge sys_clk);
               sys_rst = 1'b0;
               wait_den(G + 20, seen);
               OE = 1'b0;
               @(negedge sys_clk);
            end
         endcase
         repeat (2) @(negedge sys_clk);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pulse_gate_counter.md
# pulse_gate_counter

Gated pulse counter: the responder side of the `OE` / `counter_data_en` handshake driven by the frequency-counter control block. When `OE` rises, it opens a fixed-length gate, counts rising edges of the external test signal, then publishes the count with `counter_data_en`. `counter_data_en` is held until the controller drops `OE`. It sits between the external signal input and the frequency computation/display path.

## Interface
- `GATE_CYCLES`, 50_000_000: gate length in `sys_clk` cycles (1 s at 50 MHz); must be ≥ 2.
- `CNT_W`, 32: width of the pulse count.
- `FILTER_CYCLES`, 4: stability length for the glitch filter (used only with the macro); must be ≥ 1.

Ports:
- `sys_clk` input 1: single clock.
- `sys_rst` input 1: synchronous, active-high reset.
- `OE` input 1: measurement request from the controller; level, held high until `counter_data_en` is seen.
- `sig_in` input 1: external signal under test; asynchronous to `sys_clk`.
- `counter_data_en` output 1: result valid; level handshake.
- `pulse_count` output CNT_W: edge count of the last completed gate.
- `cnt_ovf` output 1: last completed gate saturated the count.

## Operation
- Input path:
  - `sig_in` passes through a 2-FF synchronizer, then a registered rising-edge detector (`edge_p`).
  - Edge-to-`edge_p` latency is 3 cycles.
- FSM states:
  - **IDLE**: `counter_data_en`=0. When `OE`=1, clear `gate_cnt` and `acc`, clear `acc_ovf`, and go to GATE.
  - **GATE**:
    - Each cycle, increment `gate_cnt`.
    - If `edge_p`=1, increment `acc`. At `acc` = 2^CNT_W−1, hold `acc` and set `acc_ovf`.
    - If `OE`=0 at any GATE cycle, abort: go to IDLE. `pulse_count` and `cnt_ovf` are not updated.
    - On the cycle `gate_cnt`==GATE_CYCLES−1: load `pulse_count` with `acc` including this cycle's `edge_p`, load `cnt_ovf` with `acc_ovf` likewise, and go to DONE.
  - **DONE**: `counter_data_en`=1. Stay while `OE`=1. When `OE`=0, go to IDLE.
- `pulse_count` and `cnt_ovf` change only on the GATE→DONE transition. They are stable at all other times, including across aborts.
- `OE` high in IDLE immediately after DONE starts a new gate; there is no mandatory idle gap beyond the one IDLE cycle.
- Reset, including mid-gate: state=IDLE, `counter_data_en`=0, `pulse_count`=0, `cnt_ovf`=0, `acc`=0, `gate_cnt`=0, synchronizer and filter flops=0. No edge is falsely detected on the first cycle after reset.

## Timing
- Let C0 be the cycle `OE`=1 is sampled in IDLE. GATE occupies cycles C0+1 … C0+GATE_CYCLES.
- Counted edges are those whose `edge_p` asserts in that window, i.e. `sig_in` rising roughly within C0−2 … C0+GATE_CYCLES−3. This is 3 cycles earlier than the window; add FILTER_CYCLES to the latency with the filter enabled.
- `counter_data_en` rises at C0+GATE_CYCLES+1, together with the new `pulse_count`/`cnt_ovf`.
- `counter_data_en` falls the cycle after `OE`=0 is sampled in DONE.
- A new gate starts no earlier than 2 cycles after `counter_data_en` falls.
- `counter_data_en` is registered. No combinational path exists from any input to any output.

## Configuration
- `PULSE_CNT_GLITCH_FILTER_EN` defined:
  - A filter sits between the synchronizer and the edge detector.
  - The filtered level changes only after the synchronized input has held the new value for FILTER_CYCLES consecutive cycles.
  - Pulses or gaps shorter than FILTER_CYCLES are ignored. Latency grows by FILTER_CYCLES.
- Not defined: the synchronizer output feeds the edge detector directly and FILTER_CYCLES is unused.

## Test plan
- Reset: hold `sys_rst`=1 for 3 cycles with `OE`=1 and `sig_in` toggling → `counter_data_en`=0, `pulse_count`=0, `cnt_ovf`=0; first gate starts only after release.
- Basic count: GATE_CYCLES=100, `sig_in` period 10 (5 high/5 low), first rise 2 cycles after C0, `OE` held → `counter_data_en`=1 at C0+101, `pulse_count`=10, `cnt_ovf`=0.
- Handshake:
  - Keep `OE`=1 for 20 cycles after `counter_data_en` → `counter_data_en` stays 1 and `pulse_count` stays stable.
  - Drop `OE` → `counter_data_en`=0 next cycle.
  - Re-raise `OE` with `sig_in` period 20 → second result `pulse_count`=5.
- Abort: after a completed result of 10, raise `OE`, then drop it at gate cycle 50 → `counter_data_en` never rises; `pulse_count` stays 10.
- Overflow: CNT_W=4, GATE_CYCLES=100, `sig_in` period 4 → 25 edges seen; `pulse_count`=15, `cnt_ovf`=1. The next gate with `sig_in` static gives `pulse_count`=0, `cnt_ovf`=0.
- Filter: FILTER_CYCLES=4, `sig_in` 2-cycle high glitches every 10 cycles over one gate → with `PULSE_CNT_GLITCH_FILTER_EN`, `pulse_count`=0; without it, `pulse_count`=10.
